// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with tear-free frame updates,
// leading-zero blanking, per-digit decimal points and an anti-ghost blank gap per slot.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [DIV_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_pend_digits;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [DATA_W-1:0]     r_act_digits;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_blank;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_hi_zero;
  logic                  w_lz_hit;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes render as 'E'.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h06;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_div_cnt == DIV_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_blank    = (32'(r_div_cnt) < BLANK_CYCLES);

  // Select the scanned digit and check whether every more-significant digit is zero.
  always_comb begin
    w_nib     = 4'd0;
    w_dp_bit  = 1'b0;
    w_hi_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_nib    = r_act_digits[4*i +: 4];
        w_dp_bit = r_act_dp[i];
      end else if ((IDX_W'(i) > r_idx) && (r_act_digits[4*i +: 4] != 4'd0)) begin
        w_hi_zero = 1'b0;
      end
    end
  end

  assign w_lz_hit = lz_blank && (w_nib == 4'd0) && w_hi_zero && (r_idx != '0);

  // Next output pattern for the current slot position.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    w_an_nxt  = '1;
    if (!w_blank) begin
      w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
      w_dp_nxt  = ~w_dp_bit;
      w_seg_nxt = w_lz_hit ? SEG_OFF : decode(w_nib);
    end
  end

  // Slot divider and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Pending copy follows load; active copy changes only at frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
    end else begin
      if (load) begin
        r_pend_digits <= digits_in;
        r_pend_dp     <= dp_in;
      end
      if (w_wrap) begin
        r_act_digits <= load ? digits_in : r_pend_digits;
        r_act_dp     <= load ? dp_in     : r_pend_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_n      <= w_seg_nxt;
      r_dp_n       <= w_dp_nxt;
      r_an_n       <= w_an_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1.
module tb_seven_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned BC = 1;

  logic          clk;
  logic          rst_n;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0] dp_in;
  logic          load;
  logic          lz_blank;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] an_n;
  logic          frame_done;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .lz_blank  (lz_blank),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [15:0]    digits;
    logic [3:0]     dp;
    logic           lz;
    logic [3:0][6:0] seg;   // expected seg_n, index = digit
  } vec_t;

  vec_t vecs[10];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Returns at the negedge where frame_done is seen; n = negedges waited.
  task automatic wait_frame(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((frame_done !== 1'b1) && (n < 40));
    if (frame_done !== 1'b1)
      chk($sformatf("%s frame_done timeout", name), 32'(frame_done), 32'd1);
  endtask

  // Starting one negedge before slot 0 begins: check the blank cycle, then each digit mid-slot.
  task automatic check_frame(input string name, input logic [3:0][6:0] seg, input logic [3:0] dp);
    logic [3:0] exp_an;
    logic       exp_dp;
    @(negedge clk);
    chk($sformatf("%s blank an_n", name), 32'(an_n), 32'hF);
    chk($sformatf("%s blank seg_n", name), 32'(seg_n), 32'h7F);
    chk($sformatf("%s blank dp_n", name), 32'(dp_n), 32'd1);
    chk($sformatf("%s frame_done low", name), 32'(frame_done), 32'd0);
    for (int d = 0; d < 4; d++) begin
      if (d == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      exp_an = ~(4'b0001 << d);
      exp_dp = ~dp[d];
      chk($sformatf("%s d%0d an_n", name, d), 32'(an_n), 32'(exp_an));
      chk($sformatf("%s d%0d seg_n", name, d), 32'(seg_n), 32'(seg[d]));
      chk($sformatf("%s d%0d dp_n", name, d), 32'(dp_n), 32'(exp_dp));
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    load      = 1'b0;
    lz_blank  = 1'b0;

    // seg fields listed {d3,d2,d1,d0}
    vecs[0] = '{"zeros",      16'h0000, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[1] = '{"v1234",      16'h1234, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{"v00A5_lz",   16'h00A5, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h06, 7'h12}};
    vecs[3] = '{"v0000_lz",   16'h0000, 4'h4, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{"v9876_dp",   16'h9876, 4'h9, 1'b0, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[5] = '{"v0B0C_lz",   16'h0B0C, 4'h0, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h06}};
    vecs[6] = '{"v0305_lzdp", 16'h0305, 4'hF, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}};
    vecs[7] = '{"v4000_lz",   16'h4000, 4'h0, 1'b1, {7'h19, 7'h40, 7'h40, 7'h40}};
    vecs[8] = '{"v0000_nolz", 16'h0000, 4'h2, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[9] = '{"vF000_lz",   16'hF000, 4'h0, 1'b1, {7'h06, 7'h40, 7'h40, 7'h40}};

    repeat (3) @(negedge clk);
    chk("reset seg_n", 32'(seg_n), 32'h7F);
    chk("reset an_n", 32'(an_n), 32'hF);
    chk("reset dp_n", 32'(dp_n), 32'd1);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    check_frame("post_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0);
    wait_frame("first", n);
    chk("first frame_done position", 32'(n), 32'd2);
    wait_frame("period", n);
    chk("frame period", 32'(n), 32'd16);

    for (int v = 0; v < 10; v++) begin
      digits_in = vecs[v].digits;
      dp_in     = vecs[v].dp;
      lz_blank  = vecs[v].lz;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
      digits_in = 16'hFFFF;
      dp_in     = 4'hF;
      wait_frame(vecs[v].name, n);
      check_frame(vecs[v].name, vecs[v].seg, vecs[v].dp);
    end

    // Mid-frame load must not tear the frame in progress (showing F000).
    wait_frame("midload", n);
    repeat (2) @(negedge clk);
    chk("midload d0 seg_n", 32'(seg_n), 32'h40);
    digits_in = 16'h1234;
    dp_in     = 4'h0;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    digits_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("midload d1 an_n", 32'(an_n), 32'hD);
    chk("midload d1 seg_n", 32'(seg_n), 32'h40);
    repeat (4) @(negedge clk);
    chk("midload d2 seg_n", 32'(seg_n), 32'h40);
    repeat (4) @(negedge clk);
    chk("midload d3 seg_n", 32'(seg_n), 32'h06);
    wait_frame("midload_next", n);
    check_frame("midload_next", {7'h79, 7'h24, 7'h30, 7'h19}, 4'h0);

    // Load coinciding with the wrap edge goes straight to active and pending.
    wait_frame("wrapload_sync", n);
    repeat (15) @(negedge clk);
    digits_in = 16'h9876;
    dp_in     = 4'h9;
    lz_blank  = 1'b0;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    digits_in = 16'h5555;
    dp_in     = 4'h0;
    chk("wrapload frame_done", 32'(frame_done), 32'd1);
    check_frame("wrapload", {7'h10, 7'h00, 7'h78, 7'h02}, 4'h9);
    wait_frame("wrapload_pend", n);
    check_frame("wrapload_pend", {7'h10, 7'h00, 7'h78, 7'h02}, 4'h9);

    // Reset mid-slot of digit 2.
    wait_frame("midreset_sync", n);
    repeat (11) @(negedge clk);
    chk("pre-reset an_n", 32'(an_n), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("midreset an_n", 32'(an_n), 32'hF);
    chk("midreset seg_n", 32'(seg_n), 32'h7F);
    chk("midreset dp_n", 32'(dp_n), 32'd1);
    chk("midreset frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("after_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0);
    wait_frame("after_reset_fd", n);
    chk("after_reset frame_done position", 32'(n), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
